// File: rtl/mem_burst_ctrl_pkg.sv
// Shared defaults and state encoding for the memory burst controller.
package mem_burst_ctrl_pkg;

   localparam int MEM_WIDTH_DEF  = 8;
   localparam int DATA_WIDTH_DEF = 16;
   localparam int LEN_WIDTH_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_FILL  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/mem_burst_ctrl_burst_counter.sv
// Loadable burst address/remaining-count pair; last_o flags the final word.
module mem_burst_ctrl_burst_counter #(
   parameter int AW = 8,
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          step_i,
   input  logic [AW-1:0] addr_i,
   input  logic [LW-1:0] len_i,
   output logic [AW-1:0] addr_o,
   output logic          last_o
);

   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] rem_q, rem_d;

   // Address wraps naturally at the top of memory.
   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load_i) begin
         addr_d = addr_i;
         rem_d  = len_i;
      end else if (step_i) begin
         addr_d = addr_q + 1'b1;
         rem_d  = rem_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = (rem_q == '0);

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst initiator for a single-port memory with 1-cycle registered output:
// read bursts, constant-fill bursts, and a response stream back to the datapath.
module mem_burst_ctrl
   import mem_burst_ctrl_pkg::*;
#(
   parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [MEM_WIDTH-1:0]  req_addr_i,
   input  logic [LEN_WIDTH-1:0]  req_len_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   output logic                  rsp_last_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  mem_we_o,
   output logic [MEM_WIDTH-1:0]  mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_din_o,
   input  logic [DATA_WIDTH-1:0] mem_dout_i
);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  last_q, last_d;
   logic                  load, step, cnt_last;
   logic [MEM_WIDTH-1:0]  cur_addr;

   mem_burst_ctrl_burst_counter #(
      .AW (MEM_WIDTH),
      .LW (LEN_WIDTH)
   ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .step_i (step),
      .addr_i (req_addr_i),
      .len_i  (req_len_i),
      .addr_o (cur_addr),
      .last_o (cnt_last)
   );

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      step       = 1'b0;
      fill_val_d = fill_val_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               load       = 1'b1;
               fill_val_d = req_wdata_i;
               state_d    = req_we_i ? ST_FILL : ST_READ;
            end
         end
         ST_READ, ST_FILL: begin
            step = 1'b1;
            if (cnt_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Memory output is valid the cycle after each read address, and after
   // the final fill write (write-through echo serves as the fill ack).
   always_comb begin
      rd_pend_d = (state_q == ST_READ) || ((state_q == ST_FILL) && cnt_last);
      last_d    = ((state_q == ST_READ) || (state_q == ST_FILL)) && cnt_last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fill_val_q <= '0;
         rd_pend_q  <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_val_q <= fill_val_d;
         rd_pend_q  <= rd_pend_d;
         last_q     <= last_d;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign mem_we_o    = (state_q == ST_FILL);
   assign mem_addr_o  = cur_addr;
   assign mem_din_o   = fill_val_q;
   assign rsp_valid_o = rd_pend_q;
   assign rsp_last_o  = last_q;
   assign rsp_rdata_o = mem_dout_i;

endmodule
